// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: turns PS/2 mouse packets into a bounded cursor position, click pulses and an LED debug view.
// Define CURSOR_WRAP_EN to make the cursor wrap at the screen edges instead of saturating.
module mouse_cursor_tracker #(
   parameter int POS_W            = 10,
   parameter int X_MAX            = 639,
   parameter int Y_MAX            = 479,
   parameter int X_INIT           = 320,
   parameter int Y_INIT           = 240,
   parameter int SENS_SHIFT       = 0,
   parameter int DBL_CLICK_CYCLES = 25000000
) (
   input  logic             CLK_100MHZ,
   input  logic             reset,
   input  logic             data_valid,
   input  logic [8:0]       x_increment,
   input  logic [8:0]       y_increment,
   input  logic             x_overflow,
   input  logic             y_overflow,
   input  logic             left_button,
   input  logic             right_button,
   input  logic [1:0]       led_sel,
   output logic [POS_W-1:0] cursor_x,
   output logic [POS_W-1:0] cursor_y,
   output logic             moved,
   output logic             left_click,
   output logic             right_click,
   output logic             double_click,
   output logic [7:0]       LED
);
   localparam int W  = POS_W + 2;
   localparam int CW = $clog2(DBL_CLICK_CYCLES + 1);
   localparam logic signed [W-1:0] XM       = W'(X_MAX);
   localparam logic signed [W-1:0] YM       = W'(Y_MAX);
   localparam logic [POS_W-1:0]    X0       = POS_W'(X_INIT);
   localparam logic [POS_W-1:0]    Y0       = POS_W'(Y_INIT);
   localparam logic [CW-1:0]       CNT_LOAD = CW'(DBL_CLICK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, FIRST_DOWN, WAIT_SECOND, SECOND_DOWN} state_t;

   function automatic logic signed [W-1:0] scale(input logic [8:0] inc, input logic ovf);
      logic signed [W-1:0] v;
      v = ovf ? (inc[8] ? {{(W-9){1'b1}}, 9'h100} : {{(W-9){1'b0}}, 9'h0FF}) : {{(W-9){inc[8]}}, inc};
      return v >>> SENS_SHIFT;
   endfunction

   function automatic logic [POS_W-1:0] fit(input logic signed [W-1:0] n, input logic signed [W-1:0] m);
      logic signed [W-1:0] r;
`ifdef CURSOR_WRAP_EN
      r = n < 0 ? n + m + W'(1) : (n > m ? n - m - W'(1) : n);
`else
      r = n < 0 ? '0 : (n > m ? m : n);
`endif
      return r[POS_W-1:0];
   endfunction

   logic                s1_valid;
   logic signed [W-1:0] s1_dx, s1_dy, nx, ny;
   logic                left_q, right_q, l_rise, l_fall, r_rise;
   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic                dbl_n, dbl_stk, mv_stk;
   logic [7:0]          led_n;

   assign nx     = $signed({2'b00, cursor_x}) + s1_dx;
   assign ny     = $signed({2'b00, cursor_y}) + s1_dy;
   assign l_rise = left_button & ~left_q;
   assign l_fall = ~left_button & left_q;
   assign r_rise = right_button & ~right_q;
   assign led_n  = led_sel == 2'd0 ? {x_increment[8], x_increment[4:0], left_button, right_button} :
                   led_sel == 2'd1 ? cursor_x[POS_W-1 -: 8] :
                   led_sel == 2'd2 ? cursor_y[POS_W-1 -: 8] :
                   {state, 4'b0, dbl_stk, mv_stk};

   // The window counter only means something in WAIT_SECOND; a rise on its last (zero) cycle is a timeout.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dbl_n   = 1'b0;
      case (state)
         IDLE:        if (l_rise) state_n = FIRST_DOWN;
         FIRST_DOWN:  if (l_fall) begin
            state_n = WAIT_SECOND;
            cnt_n   = CNT_LOAD;
         end
         WAIT_SECOND: if (cnt == '0) state_n = l_rise ? FIRST_DOWN : IDLE;
            else if (l_rise) begin
               state_n = SECOND_DOWN;
               dbl_n   = 1'b1;
            end else cnt_n = cnt - CW'(1);
         SECOND_DOWN: if (l_fall) state_n = IDLE;
         default:     state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK_100MHZ or negedge reset) begin
      if (!reset) begin
         s1_valid     <= 1'b0;
         s1_dx        <= '0;
         s1_dy        <= '0;
         cursor_x     <= X0;
         cursor_y     <= Y0;
         moved        <= 1'b0;
         left_q       <= 1'b0;
         right_q      <= 1'b0;
         left_click   <= 1'b0;
         right_click  <= 1'b0;
         double_click <= 1'b0;
         state        <= IDLE;
         cnt          <= '0;
         dbl_stk      <= 1'b0;
         mv_stk       <= 1'b0;
         LED          <= '0;
      end else begin
         s1_valid <= data_valid;
         if (data_valid) begin
            s1_dx <= scale(x_increment, x_overflow);
            s1_dy <= -scale(y_increment, y_overflow);
         end
         moved <= s1_valid;
         if (s1_valid) begin
            cursor_x <= fit(nx, XM);
            cursor_y <= fit(ny, YM);
         end
         left_q       <= left_button;
         right_q      <= right_button;
         left_click   <= l_rise;
         right_click  <= r_rise;
         double_click <= dbl_n;
         state        <= state_n;
         cnt          <= cnt_n;
         dbl_stk      <= dbl_stk | double_click;
         mv_stk       <= mv_stk | moved;
         LED          <= led_n;
      end
   end
endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// tb_mouse_cursor_tracker: two trackers (sensitivity shift 0 and 2) checked every cycle against a
// timestamp/queue model of the cursor and click rules, plus hand-computed literal expectations.
module tb_mouse_cursor_tracker;
   localparam int DBL = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dv = 1'b0, xo = 1'b0, yo = 1'b0, lb = 1'b0, rb = 1'b0;
   logic [8:0] xi = '0, yi = '0;
   logic [1:0] sel = '0;
   logic [9:0] cx [2];
   logic [9:0] cy [2];
   logic [7:0] led [2];
   logic mv [2];
   logic lc [2];
   logic rc [2];
   logic dc [2];
   int tests = 0, fails = 0;
   int nl = 0, nr = 0, nd = 0, nboth = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mouse_cursor_tracker #(.SENS_SHIFT(0), .DBL_CLICK_CYCLES(DBL)) u_a (
      .CLK_100MHZ(clk), .reset(reset), .data_valid(dv), .x_increment(xi), .y_increment(yi),
      .x_overflow(xo), .y_overflow(yo), .left_button(lb), .right_button(rb), .led_sel(sel),
      .cursor_x(cx[0]), .cursor_y(cy[0]), .moved(mv[0]), .left_click(lc[0]), .right_click(rc[0]),
      .double_click(dc[0]), .LED(led[0]));

   mouse_cursor_tracker #(.SENS_SHIFT(2), .DBL_CLICK_CYCLES(DBL)) u_b (
      .CLK_100MHZ(clk), .reset(reset), .data_valid(dv), .x_increment(xi), .y_increment(yi),
      .x_overflow(xo), .y_overflow(yo), .left_button(lb), .right_button(rb), .led_sel(sel),
      .cursor_x(cx[1]), .cursor_y(cy[1]), .moved(mv[1]), .left_click(lc[1]), .right_click(rc[1]),
      .double_click(dc[1]), .LED(led[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Signed increment after overflow substitution, then floor-divided by 2^sh.
   function automatic int delta(input logic [8:0] inc, input logic ovf, input int sh);
      int v, p;
      v = ovf ? (inc[8] ? -256 : 255) : (inc[8] ? int'(inc) - 512 : int'(inc));
      p = 1 << sh;
      return v >= 0 ? v / p : -((-v + p - 1) / p);
   endfunction

   function automatic int fit(input int n, input int mx);
`ifdef CURSOR_WRAP_EN
      return n < 0 ? n + mx + 1 : (n > mx ? n - mx - 1 : n);
`else
      return n < 0 ? 0 : (n > mx ? mx : n);
`endif
   endfunction

   typedef struct {int due; logic [8:0] x; logic [8:0] y; logic xo; logic yo;} pkt_t;
   pkt_t q[$];
   int k, last_rel;
   int m_cx [2];
   int m_cy [2];
   logic [7:0] m_led [2];
   bit m_mv, m_lc, m_rc, m_dc, pl, pr, second, down, dstk, mstk;
   bit [1:0] m_st;

   always @(posedge clk or negedge reset) begin : model
      pkt_t p;
      if (!reset) begin
         k = 0; last_rel = -1; q.delete();
         m_mv = 0; m_lc = 0; m_rc = 0; m_dc = 0; pl = 0; pr = 0; second = 0; down = 0;
         dstk = 0; mstk = 0; m_st = 0;
         for (int i = 0; i < 2; i++) begin
            m_cx[i] = 320; m_cy[i] = 240; m_led[i] = '0;
         end
      end else begin
         for (int i = 0; i < 2; i++)
            m_led[i] = sel == 2'd0 ? {xi[8], xi[4:0], lb, rb} : sel == 2'd1 ? 8'(m_cx[i] >> 2) :
                       sel == 2'd2 ? 8'(m_cy[i] >> 2) : {m_st, 4'b0, dstk, mstk};
         dstk = dstk | m_dc;
         mstk = mstk | m_mv;
         k++;
         m_mv = 0;
         if (q.size() > 0 && q[0].due == k) begin
            p = q.pop_front();
            for (int i = 0; i < 2; i++) begin
               m_cx[i] = fit(m_cx[i] + delta(p.x, p.xo, 2 * i), 639);
               m_cy[i] = fit(m_cy[i] - delta(p.y, p.yo, 2 * i), 479);
            end
            m_mv = 1;
         end
         if (dv) begin
            p.due = k + 1; p.x = xi; p.y = yi; p.xo = xo; p.yo = yo;
            q.push_back(p);
         end
         m_lc = lb & !pl;
         m_rc = rb & !pr;
         m_dc = 0;
         if (m_lc) begin
            m_dc = last_rel >= 0 && k - last_rel <= DBL - 1;
            second = m_dc; last_rel = -1; down = 1;
         end else if (!lb && pl) begin
            if (!second) last_rel = k;
            second = 0; down = 0;
         end
         pl = lb; pr = rb;
         m_st = down ? (second ? 2'd3 : 2'd1) : (last_rel >= 0 && k - last_rel <= DBL - 1) ? 2'd2 : 2'd0;
      end
   end

   always @(negedge clk) begin
      if (chk_en)
         for (int i = 0; i < 2; i++) begin
            check($sformatf("cursor_x[%0d]", i), 32'(cx[i]), m_cx[i]);
            check($sformatf("cursor_y[%0d]", i), 32'(cy[i]), m_cy[i]);
            check($sformatf("moved[%0d]", i), 32'(mv[i]), 32'(m_mv));
            check($sformatf("left_click[%0d]", i), 32'(lc[i]), 32'(m_lc));
            check($sformatf("right_click[%0d]", i), 32'(rc[i]), 32'(m_rc));
            check($sformatf("double_click[%0d]", i), 32'(dc[i]), 32'(m_dc));
            check($sformatf("LED[%0d]", i), 32'(led[i]), 32'(m_led[i]));
         end
      nl += int'(lc[0]); nr += int'(rc[0]); nd += int'(dc[0]); nboth += int'(lc[0] & rc[0]);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pkt(input logic [8:0] x, input logic [8:0] y, input logic ox, input logic oy);
      dv = 1; xi = x; yi = y; xo = ox; yo = oy;
      tick(1);
      dv = 0; xo = 0; yo = 0;
      tick(1);
   endtask

   task automatic click_seq(input int gap);
      nl = 0; nr = 0; nd = 0; nboth = 0;
      lb = 1; tick(2); lb = 0; tick(gap); lb = 1; tick(2); lb = 0; tick(12);
   endtask

   initial begin
      #1 reset = 0;
      #1 chk_en = 1;
      tick(3);
      reset = 1; sel = 1;
      tick(1);
      check("reset_x", 32'(cx[0]), 320);
      check("reset_y", 32'(cy[0]), 240);
      check("reset_pulses", {mv[0], lc[0], rc[0], dc[0]}, 0);
      check("reset_led_x", 32'(led[0]), 32'h50);
      pkt(9'h00A, 9'h005, 0, 0);
      check("move_x", 32'(cx[0]), 330);
      check("move_y", 32'(cy[0]), 235);
      check("moved_on", 32'(mv[0]), 1);
      tick(1);
      check("moved_off", 32'(mv[0]), 0);
      pkt(9'h000, 9'h000, 0, 0);
      check("zero_moved", 32'(mv[0]), 1);
      check("zero_x", 32'(cx[0]), 330);
      sel = 2;
      pkt(9'h0FF, 9'h000, 0, 0);
      pkt(9'h02D, 9'h000, 0, 0);
      check("x_630", 32'(cx[0]), 630);
      pkt(9'h014, 9'h000, 0, 0);
`ifdef CURSOR_WRAP_EN
      check("x_edge", 32'(cx[0]), 10);
`else
      check("x_edge", 32'(cx[0]), 639);
`endif
      dv = 1; xi = 9'h1FD; tick(1); xi = 9'h1FC; tick(1); dv = 0; tick(1);
`ifdef CURSOR_WRAP_EN
      check("b2b_x", 32'(cx[0]), 3);
`else
      check("b2b_x", 32'(cx[0]), 632);
`endif
      check("b2b_moved", 32'(mv[0]), 1);
      sel = 0;
      pkt(9'h000, 9'h100, 0, 1);
`ifdef CURSOR_WRAP_EN
      check("y_edge", 32'(cy[0]), 11);
`else
      check("y_edge", 32'(cy[0]), 479);
`endif
      tick(2);
      sel = 3;
      dv = 1; xi = 9'h050; tick(1); xi = 9'h060; reset = 0;
      #1;
      check("async_x", 32'(cx[0]), 320);
      check("async_y", 32'(cy[0]), 240);
      check("async_moved", 32'(mv[0]), 0);
      check("async_led", 32'(led[0]), 0);
      tick(2);
      dv = 0; reset = 1;
      tick(3);
      check("discard_x", 32'(cx[0]), 320);
      sel = 1;
      pkt(9'h138, 9'h000, 0, 0);
      pkt(9'h1EC, 9'h000, 0, 0);
      check("x_100", 32'(cx[0]), 100);
      pkt(9'h1F0, 9'h000, 1, 0);
`ifdef CURSOR_WRAP_EN
      check("ovf_x", 32'(cx[0]), 484);
`else
      check("ovf_x", 32'(cx[0]), 0);
`endif
      repeat (4) pkt(9'h1F0, 9'h000, 1, 0);
      pkt(9'h1FF, 9'h000, 0, 0);
`ifdef CURSOR_WRAP_EN
      check("minus1_a", 32'(cx[0]), 99);
      check("minus1_b", 32'(cx[1]), 584);
`else
      check("minus1_a", 32'(cx[0]), 0);
      check("minus1_b", 32'(cx[1]), 0);
`endif
      sel = 3;
      click_seq(5);
      check("dbl5_clicks", nl, 2);
      check("dbl5_dbl", nd, 1);
      click_seq(7);
      check("dbl7_dbl", nd, 1);
      click_seq(8);
      check("dbl8_dbl", nd, 0);
      click_seq(9);
      check("dbl9_clicks", nl, 2);
      check("dbl9_dbl", nd, 0);
      nl = 0; nd = 0;
      repeat (3) begin
         lb = 1; tick(2); lb = 0; tick(3);
      end
      tick(12);
      check("triple_clicks", nl, 3);
      check("triple_dbl", nd, 1);
      nl = 0; nr = 0; nboth = 0;
      lb = 1; rb = 1; tick(3); lb = 0; rb = 0; tick(12);
      check("both_left", nl, 1);
      check("both_right", nr, 1);
      check("both_same", nboth, 1);
      sel = 0; xi = 9'h1A5; tick(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
